// File: rtl/controle_pc_pkg.sv
// controle_pc_pkg: shared types and default constants for the PC sequencer.
//   estado_t            : sequencer state (EXECUTA, PARADO)
//   PC_W_PADRAO         : default program counter width
//   END_INICIAL_PADRAO  : default PC value loaded on reset
//   VETOR_INT_PADRAO    : default interrupt handler address
package controle_pc_pkg;

  localparam int unsigned PC_W_PADRAO        = 32;
  localparam logic [31:0] END_INICIAL_PADRAO = 32'd0;
  localparam logic [31:0] VETOR_INT_PADRAO   = 32'd1;

  typedef enum logic {
    EXECUTA = 1'b0,
    PARADO  = 1'b1
  } estado_t;

endpackage

// File: rtl/controle_pc_if.sv
// controle_pc_if: control/target inputs and PC outputs of the PC sequencer.
//   master : control unit / comparison stage side (drives controls and targets)
//   slave  : controle_pc side (drives pc, pc_mais_um, flush, parado)
// Optional macro CONTROLE_PC_TROCA_CONTEXTO_EN adds interrupcao, retorno_int
// and pc_salvo.
interface controle_pc_if #(
  parameter int unsigned PC_W = 32
);
  logic            stall;
  logic            branch;
  logic            resultadoComparacao;
  logic            jump;
  logic            jump_reg;
  logic            halt;
  logic            continuar;
  logic [PC_W-1:0] alvo_imediato;
  logic [PC_W-1:0] alvo_registrador;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_mais_um;
  logic            flush;
  logic            parado;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
  logic            interrupcao;
  logic            retorno_int;
  logic [PC_W-1:0] pc_salvo;

  modport master (
    output stall, branch, resultadoComparacao, jump, jump_reg, halt, continuar,
           alvo_imediato, alvo_registrador, interrupcao, retorno_int,
    input  pc, pc_mais_um, flush, parado, pc_salvo
  );
  modport slave (
    input  stall, branch, resultadoComparacao, jump, jump_reg, halt, continuar,
           alvo_imediato, alvo_registrador, interrupcao, retorno_int,
    output pc, pc_mais_um, flush, parado, pc_salvo
  );
`else
  modport master (
    output stall, branch, resultadoComparacao, jump, jump_reg, halt, continuar,
           alvo_imediato, alvo_registrador,
    input  pc, pc_mais_um, flush, parado
  );
  modport slave (
    input  stall, branch, resultadoComparacao, jump, jump_reg, halt, continuar,
           alvo_imediato, alvo_registrador,
    output pc, pc_mais_um, flush, parado
  );
`endif
endinterface

// File: rtl/controle_pc_seletor_proximo_pc.sv
// seletor_proximo_pc: combinational priority mux for the next PC.
//   Priority: halt (pc+1, no redirect) > [interrupt > return] > jump_reg >
//   jump > taken branch > pc+1.
//   prox_pc_o  : next PC value
//   redirect_o : next PC is a redirect (drives the registered flush)
// Optional macro CONTROLE_PC_TROCA_CONTEXTO_EN adds the interrupt/return path.
module seletor_proximo_pc #(
  parameter int unsigned    PC_W      = 32
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
 ,parameter logic [PC_W-1:0] VETOR_INT = '0
`endif
) (
  input  logic [PC_W-1:0] pc_mais_um_i,
  input  logic            halt_i,
  input  logic            jump_reg_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            resultado_i,
  input  logic [PC_W-1:0] alvo_imediato_i,
  input  logic [PC_W-1:0] alvo_registrador_i,
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
  input  logic            interrupcao_i,
  input  logic            retorno_int_i,
  input  logic            em_int_i,
  input  logic [PC_W-1:0] pc_salvo_i,
  output logic [PC_W-1:0] prox_normal_o,
  output logic            toma_int_o,
  output logic            toma_ret_o,
`endif
  output logic [PC_W-1:0] prox_pc_o,
  output logic            redirect_o
);

  logic [PC_W-1:0] prox_normal;
  logic            redir_normal;

  always_comb begin
    prox_normal  = pc_mais_um_i;
    redir_normal = 1'b0;
    if (!halt_i) begin
      if (jump_reg_i) begin
        prox_normal  = alvo_registrador_i;
        redir_normal = 1'b1;
      end else if (jump_i || (branch_i && resultado_i)) begin
        prox_normal  = alvo_imediato_i;
        redir_normal = 1'b1;
      end
    end
  end

`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
  // Interrupt and return are mutually exclusive through em_int.
  assign toma_int_o    = interrupcao_i & ~em_int_i & ~halt_i;
  assign toma_ret_o    = retorno_int_i &  em_int_i & ~halt_i;
  assign prox_normal_o = prox_normal;
  assign prox_pc_o     = toma_int_o ? VETOR_INT :
                         toma_ret_o ? pc_salvo_i : prox_normal;
  assign redirect_o    = toma_int_o | toma_ret_o | redir_normal;
`else
  assign prox_pc_o  = prox_normal;
  assign redirect_o = redir_normal;
`endif

endmodule

// File: rtl/controle_pc.sv
// controle_pc: program-counter sequencer after the branch comparison stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : stall/branch/resultadoComparacao/jump/jump_reg/halt/
//                  continuar and targets in; pc, pc_mais_um (comb), flush
//                  (registered redirect pulse), parado out
// Optional macro CONTROLE_PC_TROCA_CONTEXTO_EN adds interrupt entry/return
// (interrupcao, retorno_int, pc_salvo) with handler address VETOR_INT.
module controle_pc
  import controle_pc_pkg::*;
#(
  parameter int unsigned     PC_W        = PC_W_PADRAO,
  parameter logic [PC_W-1:0] END_INICIAL = PC_W'(END_INICIAL_PADRAO)
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
 ,parameter logic [PC_W-1:0] VETOR_INT   = PC_W'(VETOR_INT_PADRAO)
`endif
) (
  input  logic         clock,
  input  logic         reset,
  controle_pc_if.slave bus
);

  estado_t         estado_q, estado_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            continuar_q;
  logic [PC_W-1:0] pc_mais_um;
  logic [PC_W-1:0] prox_pc;
  logic            redirect;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
  logic            em_int_q, em_int_d;
  logic [PC_W-1:0] pc_salvo_q, pc_salvo_d;
  logic [PC_W-1:0] prox_normal;
  logic            toma_int, toma_ret;
`endif

  assign pc_mais_um = pc_q + PC_W'(1);

  seletor_proximo_pc #(
    .PC_W      (PC_W)
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
   ,.VETOR_INT (VETOR_INT)
`endif
  ) u_seletor (
    .pc_mais_um_i       (pc_mais_um),
    .halt_i             (bus.halt),
    .jump_reg_i         (bus.jump_reg),
    .jump_i             (bus.jump),
    .branch_i           (bus.branch),
    .resultado_i        (bus.resultadoComparacao),
    .alvo_imediato_i    (bus.alvo_imediato),
    .alvo_registrador_i (bus.alvo_registrador),
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
    .interrupcao_i      (bus.interrupcao),
    .retorno_int_i      (bus.retorno_int),
    .em_int_i           (em_int_q),
    .pc_salvo_i         (pc_salvo_q),
    .prox_normal_o      (prox_normal),
    .toma_int_o         (toma_int),
    .toma_ret_o         (toma_ret),
`endif
    .prox_pc_o          (prox_pc),
    .redirect_o         (redirect)
  );

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    flush_d  = 1'b0;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
    em_int_d   = em_int_q;
    pc_salvo_d = pc_salvo_q;
`endif
    case (estado_q)
      EXECUTA: begin
        if (!bus.stall) begin
          pc_d    = prox_pc;
          flush_d = redirect;
          if (bus.halt) estado_d = PARADO;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
          if (toma_int) begin
            pc_salvo_d = prox_normal;
            em_int_d   = 1'b1;
          end
          if (toma_ret) em_int_d = 1'b0;
`endif
        end
      end
      PARADO: begin
        // Resume only on a rising continuar, so a level already high when
        // halt was accepted does not release the halt.
        if (bus.continuar && !continuar_q) estado_d = EXECUTA;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= EXECUTA;
      pc_q        <= END_INICIAL;
      flush_q     <= 1'b0;
      continuar_q <= 1'b0;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
      em_int_q    <= 1'b0;
      pc_salvo_q  <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      continuar_q <= bus.continuar;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
      em_int_q    <= em_int_d;
      pc_salvo_q  <= pc_salvo_d;
`endif
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_mais_um = pc_mais_um;
  assign bus.flush      = flush_q;
  assign bus.parado     = (estado_q == PARADO);
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
  assign bus.pc_salvo   = pc_salvo_q;
`endif

endmodule

// File: tb/tb_controle_pc.sv
module tb_controle_pc;

  logic clk;
  logic rst;
  int unsigned erros;
  int unsigned verificacoes;

  controle_pc_if #(.PC_W(32)) bus ();

  controle_pc #(
    .PC_W        (32),
    .END_INICIAL (32'd0)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    verificacoes++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic limpa();
    bus.stall               = 1'b0;
    bus.branch              = 1'b0;
    bus.resultadoComparacao = 1'b0;
    bus.jump                = 1'b0;
    bus.jump_reg            = 1'b0;
    bus.halt                = 1'b0;
    bus.continuar           = 1'b0;
    bus.alvo_imediato       = '0;
    bus.alvo_registrador    = '0;
`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
    bus.interrupcao         = 1'b0;
    bus.retorno_int         = 1'b0;
`endif
  endtask

  task automatic confere(input string tag, input logic [31:0] pc, input logic fl, input logic pa);
    verifica({tag, ".pc"},     bus.pc,          pc);
    verifica({tag, ".flush"},  32'(bus.flush),  32'(fl));
    verifica({tag, ".parado"}, 32'(bus.parado), 32'(pa));
  endtask

  initial begin
    erros = 0;
    verificacoes = 0;
    limpa();
    rst = 1'b1;
    ciclo();
    confere("reset", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      ciclo();
      confere($sformatf("seq%0d", i), 32'(i), 1'b0, 1'b0);
    end
    verifica("pc_mais_um@4", bus.pc_mais_um, 32'd5);
    ciclo();
    confere("seq5", 32'd5, 1'b0, 1'b0);

    // Taken branch, one-cycle flush
    bus.branch = 1'b1; bus.resultadoComparacao = 1'b1; bus.alvo_imediato = 32'd40;
    ciclo();
    confere("br_taken", 32'd40, 1'b1, 1'b0);
    limpa();
    ciclo();
    confere("br_after", 32'd41, 1'b0, 1'b0);

    // Not-taken branch
    bus.branch = 1'b1; bus.resultadoComparacao = 1'b0; bus.alvo_imediato = 32'd40;
    ciclo();
    confere("br_not", 32'd42, 1'b0, 1'b0);

    // jump_reg beats jump
    limpa();
    bus.jump = 1'b1; bus.jump_reg = 1'b1;
    bus.alvo_imediato = 32'd10; bus.alvo_registrador = 32'd20;
    ciclo();
    confere("jr_prio", 32'd20, 1'b1, 1'b0);

    // Stall during jump holds pc and forces flush low
    bus.jump_reg = 1'b0; bus.stall = 1'b1;
    ciclo();
    confere("stall1", 32'd20, 1'b0, 1'b0);
    ciclo();
    confere("stall2", 32'd20, 1'b0, 1'b0);
    bus.stall = 1'b0;
    ciclo();
    confere("jump", 32'd10, 1'b1, 1'b0);
    limpa();
    ciclo();
    confere("jump_after", 32'd11, 1'b0, 1'b0);

    // Go to 7, then halt beats jump_reg; continuar already high is ignored
    bus.jump_reg = 1'b1; bus.alvo_registrador = 32'd7;
    ciclo();
    confere("to7", 32'd7, 1'b1, 1'b0);
    bus.halt = 1'b1; bus.alvo_registrador = 32'd100; bus.continuar = 1'b1;
    ciclo();
    confere("halt", 32'd8, 1'b0, 1'b1);
    bus.halt = 1'b0; bus.jump_reg = 1'b0;
    ciclo();
    confere("halt_cont_held", 32'd8, 1'b0, 1'b1);
    bus.continuar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.jump = (i == 1); bus.alvo_imediato = 32'd55; bus.stall = (i == 2);
      ciclo();
      confere($sformatf("halt_hold%0d", i), 32'd8, 1'b0, 1'b1);
    end
    verifica("pc_mais_um@halt", bus.pc_mais_um, 32'd9);
    limpa();
    bus.continuar = 1'b1; bus.stall = 1'b1;
    ciclo();
    confere("resume", 32'd8, 1'b0, 1'b0);
    limpa();
    ciclo();
    confere("resume_next", 32'd9, 1'b0, 1'b0);

    // Wraparound
    bus.jump_reg = 1'b1; bus.alvo_registrador = 32'hFFFF_FFFF;
    ciclo();
    confere("to_max", 32'hFFFF_FFFF, 1'b1, 1'b0);
    verifica("pc_mais_um@max", bus.pc_mais_um, 32'd0);
    limpa();
    ciclo();
    confere("wrap", 32'd0, 1'b0, 1'b0);

    // Reset while halted
    bus.halt = 1'b1;
    ciclo();
    confere("halt2", 32'd1, 1'b0, 1'b1);
    bus.halt = 1'b0;
    rst = 1'b1;
    ciclo();
    confere("rst_parado", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset over stall clears a pending flush
    bus.jump = 1'b1; bus.alvo_imediato = 32'd50;
    ciclo();
    confere("jump50", 32'd50, 1'b1, 1'b0);
    rst = 1'b1; bus.stall = 1'b1;
    ciclo();
    confere("rst_stall", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    limpa();

`ifdef CONTROLE_PC_TROCA_CONTEXTO_EN
    verifica("pc_salvo_rst", bus.pc_salvo, 32'd0);
    bus.jump_reg = 1'b1; bus.alvo_registrador = 32'd12;
    ciclo();
    confere("to12", 32'd12, 1'b1, 1'b0);
    limpa();
    bus.interrupcao = 1'b1;
    ciclo();
    confere("int", 32'd1, 1'b1, 1'b0);
    verifica("pc_salvo", bus.pc_salvo, 32'd13);
    ciclo();
    confere("int2_ignored", 32'd2, 1'b0, 1'b0);
    verifica("pc_salvo_kept", bus.pc_salvo, 32'd13);
    bus.interrupcao = 1'b0; bus.retorno_int = 1'b1;
    ciclo();
    confere("ret", 32'd13, 1'b1, 1'b0);
    bus.retorno_int = 1'b0;
    ciclo();
    confere("ret_after", 32'd14, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", erros, verificacoes);
    $finish;
  end

endmodule
